bip2_control_unit: RTL and testbench

- Multi-cycle control unit for the BIP-II datapath.
- Fetches a 16-bit instruction, decodes the opcode, and drives the accumulator-input select (SelA, 3-to-1 mux: data memory / immediate / ALU), the ALU operand select, the ALU op, and the accumulator/RAM strobes.
- Owns the PC and the IR.

---
 rtl/bip2_pkg.sv | 49 ++++
 rtl/bip2_branch_eval.sv | 26 ++
 rtl/bip2_control_unit.sv | 139 +++++++++++++
 tb/tb_bip2_control_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bip2_pkg.sv
// Shared definitions for the BIP-II control path: widths, opcodes,
// accumulator-mux encodings and the multi-cycle FSM state encoding.
package bip2_pkg;

  localparam int DATA_W  = 11;
  localparam int OPC_W   = 5;
  localparam int INSTR_W = OPC_W + DATA_W;

  localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_BNE  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_BGT  = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_BGE  = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_BLT  = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_BLE  = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_JMP  = 5'b01110;

  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_EXT = 2'b01;
  localparam logic [1:0] SEL_ULA = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_LOAD_IR = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WB      = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  function automatic logic writes_acc(input logic [OPC_W-1:0] opc);
    return (opc >= OPC_LD) && (opc <= OPC_SUBI);
  endfunction

  function automatic logic reads_dmem(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

  function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
    return opc > OPC_JMP;
  endfunction

endpackage

// File: rtl/bip2_branch_eval.sv
// Branch condition evaluation from opcode and status flags. Purely
// combinational; non-branch opcodes never report taken.
module bip2_branch_eval
  import bip2_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             z,
  input  logic             n,
  output logic             taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OPC_BEQ: taken = z;
      OPC_BNE: taken = ~z;
      OPC_BGT: taken = ~z & ~n;
      OPC_BGE: taken = ~n;
      OPC_BLT: taken = n;
      OPC_BLE: taken = n | z;
      OPC_JMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip2_control_unit.sv
// BIP-II multi-cycle control unit: FETCH -> LOAD_IR -> EXEC -> WB, owning PC
// and IR and driving the accumulator mux, ALU controls and memory strobes.
module bip2_control_unit #(
  parameter int DATA_W = bip2_pkg::DATA_W,
  parameter int OPC_W  = bip2_pkg::OPC_W
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic [OPC_W+DATA_W-1:0] instr_i,
  input  logic                    z_i,
  input  logic                    n_i,
  output logic [DATA_W-1:0]       imem_addr_o,
  output logic [DATA_W-1:0]       dmem_addr_o,
  output logic                    dmem_rd_o,
  output logic                    dmem_wr_o,
  output logic [DATA_W-1:0]       ext_o,
  output logic [1:0]              SelA_o,
  output logic                    SelB_o,
  output logic                    op_o,
  output logic                    wr_acc_o,
  output logic                    halted_o,
  output logic                    illegal_o,
  output logic [2:0]              state_dbg_o
);
  import bip2_pkg::*;

  // en_i is an advance qualifier, not a handshake: a state only moves, and a
  // strobe is only asserted, in a cycle where en_i is high; otherwise all hold.

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         pc_q, pc_d;
  logic [OPC_W+DATA_W-1:0]   ir_q;
  logic [OPC_W-1:0]          opc;
  logic                      ir_load;
  logic                      pc_update;
  logic                      taken;
  logic [1:0]                sel_a_dec;
  logic                      sel_b_dec;
  logic                      op_dec;

  assign opc         = ir_q[OPC_W+DATA_W-1 -: OPC_W];
  assign imem_addr_o = pc_q;
  assign dmem_addr_o = ir_q[DATA_W-1:0];
  assign ext_o       = ir_q[DATA_W-1:0];
  assign state_dbg_o = state_q;

  bip2_branch_eval u_branch_eval (
    .opcode (opc),
    .z      (z_i),
    .n      (n_i),
    .taken  (taken)
  );

  // Datapath select decode; only presented on the outputs during EXEC/WB.
  always_comb begin
    sel_a_dec = SEL_MEM;
    sel_b_dec = 1'b0;
    op_dec    = 1'b0;
    case (opc)
      OPC_LD:   sel_a_dec = SEL_MEM;
      OPC_LDI:  sel_a_dec = SEL_EXT;
      OPC_ADD:  sel_a_dec = SEL_ULA;
      OPC_ADDI: begin sel_a_dec = SEL_ULA; sel_b_dec = 1'b1; end
      OPC_SUB:  begin sel_a_dec = SEL_ULA; op_dec = 1'b1; end
      OPC_SUBI: begin sel_a_dec = SEL_ULA; sel_b_dec = 1'b1; op_dec = 1'b1; end
      default:  sel_a_dec = SEL_MEM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_update = 1'b0;
    dmem_rd_o = 1'b0;
    dmem_wr_o = 1'b0;
    wr_acc_o  = 1'b0;
    illegal_o = 1'b0;
    halted_o  = 1'b0;
    SelA_o    = SEL_MEM;
    SelB_o    = 1'b0;
    op_o      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (en_i) state_d = ST_LOAD_IR;
      end
      ST_LOAD_IR: begin
        if (en_i) begin
          ir_load = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        SelA_o = sel_a_dec;
        SelB_o = sel_b_dec;
        op_o   = op_dec;
        if (en_i) begin
          dmem_rd_o = reads_dmem(opc);
          dmem_wr_o = (opc == OPC_STO);
          state_d   = (opc == OPC_HLT) ? ST_HALT : ST_WB;
        end
      end
      ST_WB: begin
        SelA_o = sel_a_dec;
        SelB_o = sel_b_dec;
        op_o   = op_dec;
        if (en_i) begin
          wr_acc_o  = writes_acc(opc);
          illegal_o = is_illegal(opc);
          pc_update = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_HALT: begin
        halted_o = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // PC wraps naturally at 2^DATA_W.
  assign pc_d = taken ? ir_q[DATA_W-1:0] : pc_q + DATA_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      if (pc_update) pc_q <= pc_d;
      if (ir_load)   ir_q <= instr_i;
    end
  end

endmodule

// File: tb/tb_bip2_control_unit.sv
// Directed bench for bip2_control_unit: a vector table of instructions run
// through all four phases, then hand-written en_i, reset-abort and HALT cases.
module tb_bip2_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic [15:0] instr_i;
  logic        z_i;
  logic        n_i;
  logic [10:0] imem_addr_o;
  logic [10:0] dmem_addr_o;
  logic        dmem_rd_o;
  logic        dmem_wr_o;
  logic [10:0] ext_o;
  logic [1:0]  SelA_o;
  logic        SelB_o;
  logic        op_o;
  logic        wr_acc_o;
  logic        halted_o;
  logic        illegal_o;
  logic [2:0]  state_dbg_o;

  bip2_control_unit dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (en_i),
    .instr_i     (instr_i),
    .z_i         (z_i),
    .n_i         (n_i),
    .imem_addr_o (imem_addr_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_rd_o   (dmem_rd_o),
    .dmem_wr_o   (dmem_wr_o),
    .ext_o       (ext_o),
    .SelA_o      (SelA_o),
    .SelB_o      (SelB_o),
    .op_o        (op_o),
    .wr_acc_o    (wr_acc_o),
    .halted_o    (halted_o),
    .illegal_o   (illegal_o),
    .state_dbg_o (state_dbg_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int acc_writes = 0;
  logic [10:0] exp_q[$];

  always @(posedge clk_i) if (wr_acc_o) acc_writes++;

  typedef struct {
    logic [15:0] instr;
    logic        z;
    logic        n;
    logic [10:0] exp_pc;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_wacc;
    logic [1:0]  exp_sela;
    logic        exp_selb;
    logic        exp_op;
    logic        exp_ill;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one instruction starting in FETCH at PC cur_pc; ends in next FETCH.
  task automatic run_vec(input vec_t v, input logic [10:0] cur_pc);
    check("fetch_pc", imem_addr_o, cur_pc);
    instr_i = v.instr;
    z_i     = v.z;
    n_i     = v.n;
    step();
    check("load_ir_rd", dmem_rd_o, 0);
    step();
    check("exec_rd", dmem_rd_o, v.exp_rd);
    check("exec_wr", dmem_wr_o, v.exp_wr);
    check("exec_wacc", wr_acc_o, 0);
    check("exec_sela", SelA_o, v.exp_sela);
    check("exec_daddr", dmem_addr_o, v.instr[10:0]);
    step();
    check("wb_wacc", wr_acc_o, v.exp_wacc);
    check("wb_sela", SelA_o, v.exp_sela);
    check("wb_selb", SelB_o, v.exp_selb);
    check("wb_op", op_o, v.exp_op);
    check("wb_ext", ext_o, v.instr[10:0]);
    check("wb_illegal", illegal_o, v.exp_ill);
    check("wb_no_rd_wr", {dmem_rd_o, dmem_wr_o}, 0);
    step();
    check("next_pc", imem_addr_o, exp_q.pop_front());
    check("fetch_illegal", illegal_o, 0);
  endtask

  logic [10:0] pc_m;
  int          w0;

  initial begin
    //                instr     z     n     pc      rd    wr    wacc  selA   selB  op    ill
    tbl[0]  = '{16'h1805, 1'b0, 1'b0, 11'd1,    1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0}; // LDI 5
    tbl[1]  = '{16'h2003, 1'b0, 1'b0, 11'd2,    1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0}; // ADD 3
    tbl[2]  = '{16'h0807, 1'b0, 1'b0, 11'd3,    1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // STO 7
    tbl[3]  = '{16'h3809, 1'b0, 1'b0, 11'd4,    1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0}; // SUBI 9
    tbl[4]  = '{16'h4064, 1'b1, 1'b0, 11'd100,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // BEQ z=1
    tbl[5]  = '{16'h4064, 1'b0, 1'b0, 11'd101,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // BEQ z=0
    tbl[6]  = '{16'h68C8, 1'b0, 1'b1, 11'd200,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // BLE n=1
    tbl[7]  = '{16'h5032, 1'b0, 1'b1, 11'd201,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // BGT n=1
    tbl[8]  = '{16'h77FF, 1'b0, 1'b0, 11'd2047, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // JMP 2047
    tbl[9]  = '{16'h7800, 1'b0, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1}; // NOP wraps
    tbl[10] = '{16'h100A, 1'b1, 1'b0, 11'd1,    1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0}; // LD 10
    tbl[11] = '{16'h492C, 1'b0, 1'b0, 11'd300,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // BNE z=0
    tbl[12] = '{16'hF800, 1'b0, 1'b0, 11'd301,  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1}; // undefined

    rst_n_i = 1'b0;
    en_i    = 1'b1;
    instr_i = 16'h0000;
    z_i     = 1'b0;
    n_i     = 1'b0;
    #12;
    check("rst_pc", imem_addr_o, 0);
    check("rst_strobes", {dmem_rd_o, dmem_wr_o, wr_acc_o, illegal_o, halted_o}, 0);
    check("rst_sel", {SelA_o, SelB_o, op_o}, 0);
    check("rst_state", state_dbg_o, 0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    pc_m = 11'd0;
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(tbl[i].exp_pc);
      run_vec(tbl[i], pc_m);
      pc_m = tbl[i].exp_pc;
    end

    // en_i low for three cycles while in WB of LDI 1 at PC 301
    check("en_start_pc", imem_addr_o, 301);
    instr_i = 16'h1801;
    step();
    step();
    step();
    w0 = acc_writes;
    en_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("en_low_wacc", wr_acc_o, 0);
      check("en_low_pc", imem_addr_o, 301);
      step();
    end
    check("en_low_no_write", acc_writes - w0, 0);
    en_i = 1'b1;
    #1;
    check("en_back_wacc", wr_acc_o, 1);
    step();
    check("en_after_wacc", wr_acc_o, 0);
    check("en_one_pulse", acc_writes - w0, 1);
    check("en_next_pc", imem_addr_o, 302);

    // reset asserted during EXEC of STO 7
    instr_i = 16'h0807;
    step();
    step();
    check("sto_exec_wr", dmem_wr_o, 1);
    check("sto_exec_daddr", dmem_addr_o, 7);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("abort_wr", dmem_wr_o, 0);
    check("abort_pc", imem_addr_o, 0);
    check("abort_state", state_dbg_o, 0);
    step();
    rst_n_i = 1'b1;
    check("abort_no_wr", dmem_wr_o, 0);

    // HLT at PC 0, then random en_i for 20 cycles
    instr_i = 16'h0000;
    step();
    step();
    check("hlt_exec_halted", halted_o, 0);
    step();
    check("hlt_halted", halted_o, 1);
    for (int k = 0; k < 20; k++) begin
      en_i    = 1'($urandom_range(0, 1));
      instr_i = 16'($urandom_range(0, 65535));
      step();
      check("halt_flag", halted_o, 1);
      check("halt_pc", imem_addr_o, 0);
      check("halt_strobes", {dmem_rd_o, dmem_wr_o, wr_acc_o, illegal_o}, 0);
    end

    en_i = 1'b1;
    rst_n_i = 1'b0;
    #1;
    check("post_halt_rst", halted_o, 0);
    check("post_halt_state", state_dbg_o, 0);
    rst_n_i = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
